// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the front-side-bus hop blocks: the depth of the
// local staging FIFO and the pointer type and helper used to walk it.
package bsg_fsb_pkg;

    // Two entries are enough to cover the enqueue-to-drain latency.
    localparam int fsb_fifo_depth_gp     = 2;
    localparam int fsb_fifo_ptr_width_gp = $clog2(fsb_fifo_depth_gp);

    typedef logic [fsb_fifo_ptr_width_gp-1:0] fsb_fifo_ptr_t;

    // The depth is a power of two, so pointers wrap naturally on overflow.
    function automatic fsb_fifo_ptr_t fsb_ptr_inc(input fsb_fifo_ptr_t ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/bsg_front_side_bus_hop_out_if.sv
// Bus bundle for one front-side-bus hop output stage. The slave modport is
// the hop itself; the master modport is whatever feeds it and consumes
// its output.
interface bsg_front_side_bus_hop_out_if
#(
    parameter int width_p        = 16,
    parameter int starve_width_p = 8
);

    logic [width_p-1:0]        data_i;
    logic                      v_i;
    logic [width_p-1:0]        local_data_i;
    logic                      local_v_i;
    logic                      local_ready_o;
    logic [width_p-1:0]        data_o;
    logic                      v_o;
    logic [starve_width_p-1:0] starve_cnt_o;
    logic                      starved_o;

    modport master (
        output data_i, v_i, local_data_i, local_v_i,
        input  local_ready_o, data_o, v_o, starve_cnt_o, starved_o
    );

    modport slave (
        input  data_i, v_i, local_data_i, local_v_i,
        output local_ready_o, data_o, v_o, starve_cnt_o, starved_o
    );

endinterface

// File: rtl/bsg_fsb_hop_out_local_fifo.sv
// Two-entry FIFO that stages local traffic until the bus has an idle slot.
// Full and empty are kept as registered flags so that the enqueue ready
// never depends combinationally on the bus side.
module bsg_fsb_hop_out_local_fifo
    import bsg_fsb_pkg::*;
#(
    parameter int width_p = 16
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               deq_i
);

    logic [width_p-1:0] mem_r [fsb_fifo_depth_gp];
    fsb_fifo_ptr_t      rd_ptr_r, wr_ptr_r;
    logic               full_r, empty_r;
    logic               enq;

    assign ready_o = ~full_r & ~reset_i;
    assign enq     = v_i & ready_o;
    assign v_o     = ~empty_r;
    assign data_o  = mem_r[rd_ptr_r];

    // Pointer and occupancy-flag bookkeeping for enqueue and dequeue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (enq)
                wr_ptr_r <= fsb_ptr_inc(wr_ptr_r);
            if (deq_i)
                rd_ptr_r <= fsb_ptr_inc(rd_ptr_r);
            if (enq && !deq_i) begin
                empty_r <= 1'b0;
                full_r  <= (fsb_ptr_inc(wr_ptr_r) == rd_ptr_r);
            end else if (deq_i && !enq) begin
                full_r  <= 1'b0;
                empty_r <= (fsb_ptr_inc(rd_ptr_r) == wr_ptr_r);
            end
        end
    end

    // Storage write; contents are only meaningful behind the valid flag.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// Output-side arbiter for one front-side-bus hop. Upstream traffic has no
// flow control and always wins; local traffic waits in a small FIFO and
// fills idle slots. Defining BSG_FSB_HOP_OUT_STARVE_MON_EN adds a
// saturating counter of consecutive cycles the local head was blocked.
module bsg_front_side_bus_hop_out
    import bsg_fsb_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int starve_width_p = 8
)
(
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_front_side_bus_hop_out_if.slave   bus
);

    typedef struct packed {
        logic               v;
        logic [width_p-1:0] data;
    } hop_port_s;

    hop_port_s          next_hop;
    logic [width_p-1:0] fifo_data;
    logic               fifo_v;
    logic               fifo_deq;
    logic               v_r;
    logic [width_p-1:0] data_r;

    bsg_fsb_hop_out_local_fifo #(.width_p(width_p)) local_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (bus.local_data_i),
        .v_i     (bus.local_v_i),
        .ready_o (bus.local_ready_o),
        .data_o  (fifo_data),
        .v_o     (fifo_v),
        .deq_i   (fifo_deq)
    );

    // The local head only moves when upstream leaves the slot empty.
    assign fifo_deq = fifo_v & ~bus.v_i;

    // Pick the beat for the next bus slot: upstream first, then local.
    always_comb begin
        next_hop.v    = 1'b0;
        next_hop.data = fifo_data;
        if (bus.v_i) begin
            next_hop.v    = 1'b1;
            next_hop.data = bus.data_i;
        end else if (fifo_v) begin
            next_hop.v    = 1'b1;
            next_hop.data = fifo_data;
        end
    end

    // Output valid register; reset drops any pending beat.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            v_r <= 1'b0;
        else
            v_r <= next_hop.v;
    end

    // Output payload register; holds its value across idle slots.
    always_ff @(posedge clk_i) begin
        if (next_hop.v)
            data_r <= next_hop.data;
    end

    assign bus.v_o    = v_r;
    assign bus.data_o = data_r;

`ifdef BSG_FSB_HOP_OUT_STARVE_MON_EN
    logic [starve_width_p-1:0] starve_cnt_r, starve_cnt_n;
    logic                      starved_r;

    // Count blocked cycles, clearing whenever the local head drains or is gone.
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (fifo_deq || !fifo_v)
            starve_cnt_n = '0;
        else if (starve_cnt_r != {starve_width_p{1'b1}})
            starve_cnt_n = starve_cnt_r + 1'b1;
    end

    // Counter and saturation flag are registered together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_r <= '0;
            starved_r    <= 1'b0;
        end else begin
            starve_cnt_r <= starve_cnt_n;
            starved_r    <= (starve_cnt_n == {starve_width_p{1'b1}});
        end
    end

    assign bus.starve_cnt_o = starve_cnt_r;
    assign bus.starved_o    = starved_r;
`else
    assign bus.starve_cnt_o = {starve_width_p{1'b0}};
    assign bus.starved_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
// Directed bench for the front-side-bus hop output arbiter. Covers reset,
// upstream pass-through, local draining, collisions with a full FIFO, the
// starvation monitor (or its tie-off), and reset in mid-run.
module tb_bsg_front_side_bus_hop_out;

    localparam int width_p        = 16;
    localparam int starve_width_p = 4;

    logic clk;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    bsg_front_side_bus_hop_out_if #(.width_p(width_p), .starve_width_p(starve_width_p)) bus ();

    bsg_front_side_bus_hop_out #(.width_p(width_p), .starve_width_p(starve_width_p)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and step past the clock edge that consumes them.
    task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic lv, input logic [15:0] ld);
        bus.v_i          = v;
        bus.data_i       = d;
        bus.local_v_i    = lv;
        bus.local_data_i = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] d);
        check_output({tag, " v_o"}, 32'(bus.v_o), 32'd1);
        check_output({tag, " data_o"}, 32'(bus.data_o), 32'(d));
    endtask

    // Main directed sequence.
    initial begin
        int exp_cnt;
        reset            = 1'b1;
        bus.v_i          = 1'b0;
        bus.data_i       = '0;
        bus.local_v_i    = 1'b0;
        bus.local_data_i = '0;

        // Reset state.
        apply_stimulus(0, 16'h0, 0, 16'h0);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        check_output("reset ready", 32'(bus.local_ready_o), 32'd0);
        check_output("reset v_o", 32'(bus.v_o), 32'd0);
        check_output("reset starve_cnt", 32'(bus.starve_cnt_o), 32'd0);
        check_output("reset starved", 32'(bus.starved_o), 32'd0);
        reset = 1'b0;
        #1;
        check_output("ready after reset", 32'(bus.local_ready_o), 32'd1);

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, 16'h0, 0, 16'h0);
            check_output("idle v_o", 32'(bus.v_o), 32'd0);
            check_output("idle ready", 32'(bus.local_ready_o), 32'd1);
        end

        // Upstream only, then a back-to-back stream.
        apply_stimulus(1, 16'h1234, 0, 16'h0);
        expect_beat("upstream single", 16'h1234);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 16'h1000 + 16'(i), 0, 16'h0);
            expect_beat("upstream stream", 16'h1000 + 16'(i));
        end
        apply_stimulus(0, 16'h0, 0, 16'h0);
        check_output("upstream end v_o", 32'(bus.v_o), 32'd0);

        // Local only: two enqueues, drained in order two cycles later.
        apply_stimulus(0, 16'h0, 1, 16'hAAAA);
        check_output("local t+1 v_o", 32'(bus.v_o), 32'd0);
        check_output("local ready count1", 32'(bus.local_ready_o), 32'd1);
        apply_stimulus(0, 16'h0, 1, 16'hBBBB);
        expect_beat("local first", 16'hAAAA);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        expect_beat("local second", 16'hBBBB);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        check_output("local drained v_o", 32'(bus.v_o), 32'd0);

        // Collision: upstream holds the bus while the FIFO fills and refuses a third entry.
        apply_stimulus(1, 16'h0001, 1, 16'hAAAA);
        expect_beat("collision up1", 16'h0001);
        apply_stimulus(1, 16'h0002, 1, 16'hCCCC);
        expect_beat("collision up2", 16'h0002);
        check_output("collision full ready", 32'(bus.local_ready_o), 32'd0);
        apply_stimulus(1, 16'h0003, 1, 16'hDDDD);
        expect_beat("collision up3", 16'h0003);
        check_output("collision still full", 32'(bus.local_ready_o), 32'd0);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        expect_beat("collision local1", 16'hAAAA);
        check_output("collision ready back", 32'(bus.local_ready_o), 32'd1);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        expect_beat("collision local2", 16'hCCCC);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        check_output("collision refused v_o", 32'(bus.v_o), 32'd0);

        // Starvation: local head blocked by 20 upstream beats.
        apply_stimulus(1, 16'h0100, 1, 16'h5555);
        check_output("starve start cnt", 32'(bus.starve_cnt_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 16'h0200 + 16'(i), 0, 16'h0);
            expect_beat("starve upstream", 16'h0200 + 16'(i));
`ifdef BSG_FSB_HOP_OUT_STARVE_MON_EN
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
`else
            exp_cnt = 0;
`endif
            check_output("starve cnt", 32'(bus.starve_cnt_o), 32'(exp_cnt));
            check_output("starved", 32'(bus.starved_o), (exp_cnt == 15) ? 32'd1 : 32'd0);
        end
        apply_stimulus(0, 16'h0, 0, 16'h0);
        expect_beat("starve release", 16'h5555);
        check_output("starve cleared cnt", 32'(bus.starve_cnt_o), 32'd0);
        check_output("starve cleared flag", 32'(bus.starved_o), 32'd0);

        // Mid-run reset with a full FIFO and a valid beat in flight.
        apply_stimulus(1, 16'h0A0A, 1, 16'h1111);
        apply_stimulus(1, 16'h0B0B, 1, 16'h2222);
        expect_beat("prereset", 16'h0B0B);
        check_output("prereset ready", 32'(bus.local_ready_o), 32'd0);
        reset = 1'b1;
        apply_stimulus(0, 16'h0, 0, 16'h0);
        check_output("midreset v_o", 32'(bus.v_o), 32'd0);
        check_output("midreset ready", 32'(bus.local_ready_o), 32'd0);
        reset = 1'b0;
        #1;
        check_output("postreset ready", 32'(bus.local_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 16'h0, 0, 16'h0);
            check_output("postreset no stale", 32'(bus.v_o), 32'd0);
        end
        apply_stimulus(0, 16'h0, 1, 16'h3333);
        apply_stimulus(0, 16'h0, 0, 16'h0);
        expect_beat("postreset local", 16'h3333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
